// File: rtl/dcache_pkg.sv
// Shared types and derived geometry for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    WDONE
  } state_e;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  // Word-addressed lines: the two byte-offset bits never reach the tag.
  function automatic int tag_w(input int width, input int sets);
    return width - $clog2(sets) - 2;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid bits (cleared by reset), tags and data (never cleared).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SETS  = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [index_w(SETS)-1:0]        rd_idx,
  output logic                            rd_valid,
  output logic [tag_w(WIDTH, SETS)-1:0]   rd_tag,
  output logic [WIDTH-1:0]                rd_data,
  input  logic                            wr_en,
  input  logic [index_w(SETS)-1:0]        wr_idx,
  input  logic [tag_w(WIDTH, SETS)-1:0]   wr_tag,
  input  logic [WIDTH-1:0]                wr_data
);

  localparam int TAG_W = tag_w(WIDTH, SETS);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [WIDTH-1:0] data [SETS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, one-word-line data cache: write-through, no-write-allocate,
// zero-latency load hits, stalls the core on misses and on every store.
module dcache
  import dcache_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SETS  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] WD,
  input  logic             WE,
  input  logic             RE,
  output logic [WIDTH-1:0] RD,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  localparam int INDEX_W = index_w(SETS);
  localparam int TAG_W   = tag_w(WIDTH, SETS);

  state_e             state, state_nxt;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [WIDTH-1:0]   word_addr;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [WIDTH-1:0]   rd_data;
  logic               line_hit;
  logic               wr_en;
  logic [WIDTH-1:0]   wr_data;

  assign idx       = A[INDEX_W+1:2];
  assign tag       = A[WIDTH-1:INDEX_W+2];
  assign word_addr = A & ~WIDTH'(3);
  assign line_hit  = rd_valid && (rd_tag == tag);

  dcache_array #(
    .WIDTH (WIDTH),
    .SETS  (SETS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The core holds A/WD/WE/RE while stalled, so FILL and WRITE drive the bus straight from them.
  always_comb begin
    state_nxt = state;
    RD        = '0;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_en     = 1'b0;
    wr_data   = WD;
    case (state)
      IDLE: begin
        if (WE) begin
          stall     = 1'b1;
          wr_en     = line_hit;
          state_nxt = WRITE;
        end else if (RE) begin
          if (line_hit) begin
            RD = rd_data;
          end else begin
            stall     = 1'b1;
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = word_addr;
        if (mem_ready) begin
          wr_en     = 1'b1;
          wr_data   = mem_rdata;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = WD;
        if (mem_ready) begin
          state_nxt = WDONE;
        end
      end
      WDONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
